m_carry_accum: RTL and testbench

- Stochastic-domain carry accumulator. Sits directly downstream of the cascading-OR/carry adder stage.
- Each cycle it takes the OR output bit and the thermometer-coded carry vector and banks the surplus ones. A plain OR would lose those ones; this block re-emits them in later cycles where the OR output is 0, so the output stream preserves the true sum density up to saturation.
- A windowed ones-counter converts the corrected stream to a binary density estimate for the readout path.

---
 rtl/stoch_pkg.sv | 19 +
 rtl/m_carry_popcount.sv | 19 +
 rtl/m_carry_accum.sv | 126 ++++++++++++
 tb/tb_m_carry_accum.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - width helpers shared by the stochastic-domain carry blocks
package stoch_pkg;

  // Smallest bit count able to index 'value' distinct codes (minimum 1).
  function automatic int f_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Density estimate must hold 0..2^win_log2 inclusive.
  function automatic int f_dens_w(input int win_log2);
    return win_log2 + 1;
  endfunction

endpackage

// File: rtl/m_carry_popcount.sv
// rtl/m_carry_popcount.sv - combinational popcount of a carry vector
module m_carry_popcount
  import stoch_pkg::*;
#(
  parameter int N = 2,
  parameter int W = f_clog2(N + 1)
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/m_carry_accum.sv
// rtl/m_carry_accum.sv - carry banking accumulator with windowed density readout (OVF via M_CARRY_ACCUM_OVF_EN)
module m_carry_accum
  import stoch_pkg::*;
#(
  parameter int N_CARRY  = 2,
  parameter int CNT_W    = 4,
  parameter int WIN_LOG2 = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      CLR,
  input  logic                      OR_IN,
  input  logic [N_CARRY-1:0]        CARRY_IN,
  output logic                      OUT,
  output logic [f_dens_w(WIN_LOG2)-1:0] DENS,
  output logic                      DENS_VALID
`ifdef M_CARRY_ACCUM_OVF_EN
  ,
  output logic                      OVF
`endif
);

  localparam int INC_W  = f_clog2(N_CARRY + 1);
  localparam int SUM_W  = CNT_W + 2;
  localparam int DENS_W = f_dens_w(WIN_LOG2);
  localparam int WP_W   = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [INC_W-1:0]  inc;
  logic              have;
  logic              drain;
  logic              out_bit;
  logic [SUM_W-1:0]  cnt_sum;
  logic              sat;
  logic              wrap;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DENS_W-1:0] wcnt_q, wcnt_d;
  logic [WP_W-1:0]   wpos_q, wpos_d;
  logic              out_q, out_d;
  logic [DENS_W-1:0] dens_q, dens_d;
  logic              dv_q, dv_d;

  m_carry_popcount #(
    .N (N_CARRY),
    .W (INC_W)
  ) u_popcount (
    .bits_i  (CARRY_IN),
    .count_o (inc)
  );

  assign have    = (cnt_q != '0);
  assign out_bit = OR_IN | have;
  assign drain   = ~OR_IN & have;
  // Extra headroom bits let the overshoot be detected before clamping.
  assign cnt_sum = SUM_W'(cnt_q) + SUM_W'(inc) - SUM_W'(drain);
  assign sat     = (cnt_sum > SUM_W'(CNT_MAX));
  assign wrap    = (WIN_LOG2 == 0) || (wpos_q == WP_W'((1 << WIN_LOG2) - 1));

  always_comb begin
    cnt_d  = cnt_q;
    wcnt_d = wcnt_q;
    wpos_d = wpos_q;
    out_d  = 1'b0;
    dens_d = dens_q;
    dv_d   = 1'b0;
    if (CLR) begin
      cnt_d  = '0;
      wcnt_d = '0;
      wpos_d = '0;
    end else if (EN) begin
      cnt_d = sat ? CNT_MAX : cnt_sum[CNT_W-1:0];
      out_d = out_bit;
      if (wrap) begin
        dens_d = wcnt_q + DENS_W'(out_bit);
        wcnt_d = '0;
        wpos_d = '0;
        dv_d   = 1'b1;
      end else begin
        wcnt_d = wcnt_q + DENS_W'(out_bit);
        wpos_d = wpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      wcnt_q <= '0;
      wpos_q <= '0;
      out_q  <= 1'b0;
      dens_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wcnt_q <= wcnt_d;
      wpos_q <= wpos_d;
      out_q  <= out_d;
      dens_q <= dens_d;
      dv_q   <= dv_d;
    end
  end

  assign OUT        = out_q;
  assign DENS       = dens_q;
  assign DENS_VALID = dv_q;

`ifdef M_CARRY_ACCUM_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (CLR)            ovf_d = 1'b0;
    else if (EN && sat) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_m_carry_accum.sv
// tb/tb_m_carry_accum.sv - scoreboard bench for m_carry_accum (OVF checks with M_CARRY_ACCUM_OVF_EN)
module tb_m_carry_accum;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       CLR;
  logic       OR_IN;
  logic [1:0] CARRY_IN;
  logic       OUT;
  logic [4:0] DENS;
  logic       DENS_VALID;
`ifdef M_CARRY_ACCUM_OVF_EN
  logic       OVF;
`endif

  m_carry_accum #(.N_CARRY(2), .CNT_W(4), .WIN_LOG2(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .CLR        (CLR),
    .OR_IN      (OR_IN),
    .CARRY_IN   (CARRY_IN),
    .OUT        (OUT),
    .DENS       (DENS),
    .DENS_VALID (DENS_VALID)
`ifdef M_CARRY_ACCUM_OVF_EN
    ,
    .OVF        (OVF)
`endif
  );

  typedef struct {
    int         due;
    bit         out;
    bit         dv;
    logic [4:0] dens;
    bit         ovf;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [4:0] dens_e = 0;
  bit         ovf_e = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic step(input bit en, input bit clr, input bit orb, input logic [1:0] c,
                      input bit eo, input bit edv);
    exp_t e;
    EN = en; CLR = clr; OR_IN = orb; CARRY_IN = c;
    if (clr) ovf_e = 0;
    e.due = cyc + 1; e.out = eo; e.dv = edv; e.dens = dens_e; e.ovf = ovf_e;
    q.push_back(e);
    @(posedge CLK); #1;
  endtask

  // Monitor: compares DUT outputs against queued expectations after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("out", OUT, e.out);
        chk("dens_valid", DENS_VALID, e.dv);
        chk("dens", DENS, e.dens);
`ifdef M_CARRY_ACCUM_OVF_EN
        chk("ovf", OVF, e.ovf);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RST_N = 0; EN = 0; CLR = 0; OR_IN = 0; CARRY_IN = 0;
    #12;
    chk("reset_out", OUT, 0);
    chk("reset_dens", DENS, 0);
    chk("reset_dens_valid", DENS_VALID, 0);
    RST_N = 1;
    @(posedge CLK); #1;

    // Conservation: 3 cycles of two carries bank 6 ones -> 9 high cycles.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      step(1, 0, i < 3, (i < 3) ? 2'b11 : 2'b00, i < 9, 0);

    // Saturation: bank caps at 15, overflow at cycle 8; first window all ones.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (i >= 7) ovf_e = 1;
      if (i == 15) dens_e = 16;
      step(1, 0, i < 10, (i < 10) ? 2'b11 : 2'b00, i < 25, i == 15);
    end

    // Window of alternating bits -> 8, then all-ones window -> 16.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) dens_e = 8;
      step(1, 0, (i % 2) == 0, 2'b00, (i % 2) == 0, i == 15);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) dens_e = 16;
      step(1, 0, 1, 2'b00, 1, i == 15);
    end

    // EN low holds cnt=3 and forces OUT low; afterwards 3 ones drain.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 2'b11, 1, 0);
    step(1, 0, 1, 2'b01, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 2'b00, i < 3, 0);

    // CLR discards the bank and the carries arriving with it.
    step(1, 0, 1, 2'b11, 1, 0);
    step(1, 1, 1, 2'b11, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'b00, 0, 0);

    // Asynchronous reset mid-drain with cnt=5.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 2'b11, 1, 0);
    step(1, 0, 0, 2'b00, 1, 0);
    #3;
    OR_IN = 0; CARRY_IN = 0;
    RST_N = 0;
    #1;
    chk("async_reset_out", OUT, 0);
    chk("async_reset_dens", DENS, 0);
    chk("async_reset_dens_valid", DENS_VALID, 0);
`ifdef M_CARRY_ACCUM_OVF_EN
    chk("async_reset_ovf", OVF, 0);
`endif
    dens_e = 0; ovf_e = 0;
    @(posedge CLK); #3;
    RST_N = 1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 2'b00, 0, 0);

    @(posedge CLK); #3;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
